// File: rtl/free_list_alloc.sv
// rtl/free_list_alloc.sv - first-zero free-list allocator with occupancy vector and free count
// Optional illegal-free checking: define FREE_LIST_ALLOC_ERR_CHK_EN.
module free_list_alloc #(
    parameter int VEC_W = 16
) (
    input  logic                          Clk_i,
    input  logic                          RstN_i,
    input  logic                          AllocReq_i,
    output logic                          AllocGnt_o,
    output logic [$clog2(VEC_W)-1:0]      AllocIdx_o,
    input  logic                          FreeVld_i,
    input  logic [$clog2(VEC_W)-1:0]      FreeIdx_i,
    output logic [VEC_W-1:0]              BusyVec_o,
    output logic [$clog2(VEC_W+1)-1:0]    FreeCnt_o,
    output logic                          Full_o,
    output logic                          Empty_o,
    output logic                          FreeErr_o
);

    localparam int IDX_W = $clog2(VEC_W);
    localparam int CNT_W = $clog2(VEC_W + 1);
    localparam logic [IDX_W:0]   VEC_W_EXT = (IDX_W + 1)'(VEC_W);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(VEC_W);

    logic [VEC_W-1:0] busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             full;
    logic             gnt;
    logic [IDX_W-1:0] sel_idx;
    logic [VEC_W-1:0] gnt_onehot;
    logic [VEC_W-1:0] free_onehot;
    logic             free_in_range;
    logic             free_hit;
    logic             free_ok;

    assign full = (cnt_q == '0);

    // Descending scan so the lowest-index zero bit wins; defaults to 0 when full.
    always_comb begin
        sel_idx = '0;
        for (int i = VEC_W - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign gnt = AllocReq_i & ~full & RstN_i;

    always_comb begin
        gnt_onehot = '0;
        for (int i = 0; i < VEC_W; i++) begin
            if (gnt && (sel_idx == IDX_W'(i))) begin
                gnt_onehot[i] = 1'b1;
            end
        end
    end

    assign free_in_range = ({1'b0, FreeIdx_i} < VEC_W_EXT);

    always_comb begin
        free_hit    = 1'b0;
        free_onehot = '0;
        for (int i = 0; i < VEC_W; i++) begin
            if (FreeIdx_i == IDX_W'(i)) begin
                free_hit = busy_q[i];
                free_onehot[i] = FreeVld_i & free_in_range & busy_q[i];
            end
        end
    end

    assign free_ok = FreeVld_i & free_in_range & free_hit;

    // Granted bit is always a zero and freed bit always a one, so they never collide.
    always_comb begin
        busy_d = (busy_q | gnt_onehot) & ~free_onehot;
        cnt_d  = cnt_q;
        if (gnt && !free_ok) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (free_ok && !gnt) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk_i or negedge RstN_i) begin
        if (!RstN_i) begin
            busy_q <= '0;
            cnt_q  <= CNT_MAX;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef FREE_LIST_ALLOC_ERR_CHK_EN
    logic err_q, err_d;

    assign err_d = err_q | (FreeVld_i & ~(free_in_range & free_hit));

    always_ff @(posedge Clk_i or negedge RstN_i) begin
        if (!RstN_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign FreeErr_o = err_q;
`else
    assign FreeErr_o = 1'b0;
`endif

    assign AllocGnt_o = gnt;
    assign AllocIdx_o = sel_idx;
    assign BusyVec_o  = busy_q;
    assign FreeCnt_o  = cnt_q;
    assign Full_o     = full;
    assign Empty_o    = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_free_list_alloc.sv
// tb/tb_free_list_alloc.sv - self-checking scoreboard bench for free_list_alloc with VEC_W=4
module tb_free_list_alloc;

    logic       Clk_i = 1'b0;
    logic       RstN_i;
    logic       AllocReq_i;
    logic       AllocGnt_o;
    logic [1:0] AllocIdx_o;
    logic       FreeVld_i;
    logic [1:0] FreeIdx_i;
    logic [3:0] BusyVec_o;
    logic [2:0] FreeCnt_o;
    logic       Full_o;
    logic       Empty_o;
    logic       FreeErr_o;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

`ifdef FREE_LIST_ALLOC_ERR_CHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    free_list_alloc #(.VEC_W(4)) dut (
        .Clk_i      (Clk_i),
        .RstN_i     (RstN_i),
        .AllocReq_i (AllocReq_i),
        .AllocGnt_o (AllocGnt_o),
        .AllocIdx_o (AllocIdx_o),
        .FreeVld_i  (FreeVld_i),
        .FreeIdx_i  (FreeIdx_i),
        .BusyVec_o  (BusyVec_o),
        .FreeCnt_o  (FreeCnt_o),
        .Full_o     (Full_o),
        .Empty_o    (Empty_o),
        .FreeErr_o  (FreeErr_o)
    );

    always #5 Clk_i = ~Clk_i;

    task automatic tick();
        @(posedge Clk_i);
        #1;
    endtask

    task automatic test_reset();
        RstN_i = 1'b0; AllocReq_i = 1'b1; FreeVld_i = 1'b0; FreeIdx_i = 2'd0;
        tick(); tick();
        n_tests++;
        if (AllocGnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_gnt got %b want 0", AllocGnt_o); end
        n_tests++;
        if (BusyVec_o !== 4'b0000) begin n_fail++; $display("FAIL reset_busy got %b want 0000", BusyVec_o); end
        n_tests++;
        if (FreeCnt_o !== 3'd4) begin n_fail++; $display("FAIL reset_cnt got %0d want 4", FreeCnt_o); end
        n_tests++;
        if ({Empty_o, Full_o, FreeErr_o} !== 3'b100) begin n_fail++; $display("FAIL reset_flags got %b want 100", {Empty_o, Full_o, FreeErr_o}); end
        AllocReq_i = 1'b0;
        #2 RstN_i = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        for (int i = 0; i < 4; i++) begin
            AllocReq_i = 1'b1;
            #2;
            n_tests++;
            if (AllocGnt_o !== 1'b1) begin
                n_fail++; $display("FAIL fill_gnt%0d got %b want 1", i, AllocGnt_o);
                void'(exp_q.pop_front());
            end else begin
                int e = exp_q.pop_front();
                if (int'(AllocIdx_o) !== e) begin n_fail++; $display("FAIL fill_idx%0d got %0d want %0d", i, AllocIdx_o, e); end
            end
            tick();
        end
        n_tests++;
        if (BusyVec_o !== 4'b1111 || Full_o !== 1'b1 || FreeCnt_o !== 3'd0) begin
            n_fail++; $display("FAIL fill_full busy=%b full=%b cnt=%0d want 1111/1/0", BusyVec_o, Full_o, FreeCnt_o);
        end
        #2;
        n_tests++;
        if (AllocGnt_o !== 1'b0 || AllocIdx_o !== 2'd0) begin
            n_fail++; $display("FAIL fill_5th gnt=%b idx=%0d want 0/0", AllocGnt_o, AllocIdx_o);
        end
        AllocReq_i = 1'b0;
        tick();
    endtask

    task automatic test_full_free();
        AllocReq_i = 1'b1; FreeVld_i = 1'b1; FreeIdx_i = 2'd2;
        #2;
        n_tests++;
        if (AllocGnt_o !== 1'b0) begin n_fail++; $display("FAIL fullfree_nogrant got %b want 0", AllocGnt_o); end
        tick();
        n_tests++;
        if (FreeCnt_o !== 3'd1 || BusyVec_o !== 4'b1011) begin
            n_fail++; $display("FAIL fullfree_after cnt=%0d busy=%b want 1/1011", FreeCnt_o, BusyVec_o);
        end
        FreeVld_i = 1'b0;
        exp_q.push_back(2);
        #2;
        n_tests++;
        if (AllocGnt_o !== 1'b1) begin
            n_fail++; $display("FAIL fullfree_gnt got %b want 1", AllocGnt_o); void'(exp_q.pop_front());
        end else begin
            int e = exp_q.pop_front();
            if (int'(AllocIdx_o) !== e) begin n_fail++; $display("FAIL fullfree_idx got %0d want %0d", AllocIdx_o, e); end
        end
        tick();
        AllocReq_i = 1'b0;
        n_tests++;
        if (FreeCnt_o !== 3'd0) begin n_fail++; $display("FAIL fullfree_cnt0 got %0d want 0", FreeCnt_o); end
    endtask

    task automatic test_grant_free_same();
        FreeVld_i = 1'b1; FreeIdx_i = 2'd3; tick();
        FreeIdx_i = 2'd2; tick();
        n_tests++;
        if (BusyVec_o !== 4'b0011 || FreeCnt_o !== 3'd2) begin
            n_fail++; $display("FAIL gfs_setup busy=%b cnt=%0d want 0011/2", BusyVec_o, FreeCnt_o);
        end
        AllocReq_i = 1'b1; FreeIdx_i = 2'd0;
        exp_q.push_back(2);
        #2;
        n_tests++;
        if (AllocGnt_o !== 1'b1) begin
            n_fail++; $display("FAIL gfs_gnt got %b want 1", AllocGnt_o); void'(exp_q.pop_front());
        end else begin
            int e = exp_q.pop_front();
            if (int'(AllocIdx_o) !== e) begin n_fail++; $display("FAIL gfs_idx got %0d want %0d", AllocIdx_o, e); end
        end
        tick();
        n_tests++;
        if (BusyVec_o !== 4'b0110 || FreeCnt_o !== 3'd2) begin
            n_fail++; $display("FAIL gfs_after busy=%b cnt=%0d want 0110/2", BusyVec_o, FreeCnt_o);
        end
        FreeVld_i = 1'b0;
        exp_q.push_back(0);
        #2;
        n_tests++;
        if (AllocGnt_o !== 1'b1 || int'(AllocIdx_o) !== exp_q[0]) begin
            n_fail++; $display("FAIL gfs_refree gnt=%b idx=%0d want 1/%0d", AllocGnt_o, AllocIdx_o, exp_q[0]);
        end
        void'(exp_q.pop_front());
        tick();
        AllocReq_i = 1'b0;
        n_tests++;
        if (BusyVec_o !== 4'b0111) begin n_fail++; $display("FAIL gfs_final busy=%b want 0111", BusyVec_o); end
    endtask

    task automatic test_async_reset();
        AllocReq_i = 1'b1;
        #2 RstN_i = 1'b0;
        #1;
        n_tests++;
        if (BusyVec_o !== 4'b0000 || FreeCnt_o !== 3'd4 || AllocGnt_o !== 1'b0) begin
            n_fail++; $display("FAIL async_rst busy=%b cnt=%0d gnt=%b want 0000/4/0", BusyVec_o, FreeCnt_o, AllocGnt_o);
        end
        #3 RstN_i = 1'b1;
        exp_q.push_back(0);
        #1;
        n_tests++;
        if (AllocGnt_o !== 1'b1 || int'(AllocIdx_o) !== exp_q[0]) begin
            n_fail++; $display("FAIL async_first gnt=%b idx=%0d want 1/%0d", AllocGnt_o, AllocIdx_o, exp_q[0]);
        end
        void'(exp_q.pop_front());
        tick();
        AllocReq_i = 1'b0;
    endtask

    task automatic test_illegal_free();
        FreeVld_i = 1'b1; FreeIdx_i = 2'd3;
        tick();
        FreeVld_i = 1'b0;
        n_tests++;
        if (BusyVec_o !== 4'b0001 || FreeCnt_o !== 3'd3) begin
            n_fail++; $display("FAIL illfree_state busy=%b cnt=%0d want 0001/3", BusyVec_o, FreeCnt_o);
        end
        n_tests++;
        if (FreeErr_o !== ERR_EXP) begin n_fail++; $display("FAIL illfree_err got %b want %b", FreeErr_o, ERR_EXP); end
        tick(); tick();
        n_tests++;
        if (FreeErr_o !== ERR_EXP) begin n_fail++; $display("FAIL illfree_sticky got %b want %b", FreeErr_o, ERR_EXP); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] m_busy = 4'b0001;
        int         m_cnt  = 3;
        for (int c = 0; c < 60; c++) begin
            logic       req  = 1'($urandom_range(0, 3) != 0);
            logic       fv   = 1'($urandom_range(0, 1));
            logic [1:0] fi   = 2'($urandom_range(0, 3));
            logic       lfree = fv && m_busy[fi];
            int         pick = -1;
            for (int b = 3; b >= 0; b--) if (!m_busy[b]) pick = b;
            AllocReq_i = req; FreeVld_i = fv; FreeIdx_i = fi;
            if (req && pick >= 0) exp_q.push_back(pick);
            #2;
            n_tests++;
            if (AllocGnt_o !== (req && pick >= 0)) begin
                n_fail++; $display("FAIL b2b_gnt c%0d got %b want %b", c, AllocGnt_o, (req && pick >= 0));
                if (req && pick >= 0) void'(exp_q.pop_front());
            end else if (AllocGnt_o) begin
                int e = exp_q.pop_front();
                if (int'(AllocIdx_o) !== e) begin n_fail++; $display("FAIL b2b_idx c%0d got %0d want %0d", c, AllocIdx_o, e); end
            end
            if (req && pick >= 0) begin m_busy[pick] = 1'b1; m_cnt--; end
            if (lfree) begin m_busy[fi] = 1'b0; m_cnt++; end
            tick();
            n_tests++;
            if (BusyVec_o !== m_busy || int'(FreeCnt_o) !== m_cnt || Full_o !== (m_cnt == 0) || Empty_o !== (m_cnt == 4)) begin
                n_fail++; $display("FAIL b2b_state c%0d busy=%b cnt=%0d full=%b empty=%b want %b/%0d", c, BusyVec_o, FreeCnt_o, Full_o, Empty_o, m_busy, m_cnt);
            end
        end
        AllocReq_i = 1'b0; FreeVld_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_free();
        test_grant_free_same();
        test_async_reset();
        test_illegal_free();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
